alu_exec_stage: RTL and testbench

Registered execute stage directly downstream of alu_control. It consumes alu_a, alu_ic, alu_opcode, store_carry and store_overflow plus the top-of-stack operand, and computes the ALU result. It commits the architectural carry and overflow flags; the carry output feeds back to alu_control's carry input. Results go to writeback through a 2-entry valid/ready buffer.

---
 rtl/alu_exec_stage.sv | 145 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage.
// Computes the result of one operation per accept, commits carry/overflow
// in the accept cycle and hands results to writeback through a 2-entry
// valid/ready buffer. The flags update at accept, not at pop, so a dependent
// ADDC issued the next cycle sees the new carry.

`ifndef OP_NOP
`define OP_NOP 4'h0
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif
`ifndef OP_LSL
`define OP_LSL 4'h2
`endif
`ifndef OP_LSR
`define OP_LSR 4'h3
`endif
`ifndef OP_ASR
`define OP_ASR 4'h4
`endif
`ifndef OP_CSL
`define OP_CSL 4'h5
`endif
`ifndef OP_CSR
`define OP_CSR 4'h6
`endif
`ifndef OP_AND
`define OP_AND 4'h7
`endif
`ifndef OP_OR
`define OP_OR 4'h8
`endif
`ifndef OP_XOR
`define OP_XOR 4'h9
`endif

module alu_exec_stage #(
  parameter int WORD_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] alu_a,
  input  logic [WORD_WIDTH-1:0] alu_b,
  input  logic                  alu_ic,
  input  logic [3:0]            alu_opcode,
  input  logic                  store_carry,
  input  logic                  store_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_result,
  output logic                  carry,
  output logic                  overflow
);

  localparam int MSB = WORD_WIDTH - 1;

  logic [WORD_WIDTH-1:0]  mem [2];
  logic                   head, tail;
  logic [1:0]             count;
  logic                   accept, pop;

  logic [SHAMT_WIDTH-1:0] sh;
  logic                   ic_eff;
  logic [WORD_WIDTH:0]    sum;
  logic [WORD_WIDTH-1:0]  res;
  logic                   c_res, v_res;

  assign in_ready   = (count < 2'd2) && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_result = mem[head];

  // Carry-in gated by opcode so an unknown alu_ic never reaches a non-ADD result.
  assign ic_eff = (alu_opcode == `OP_ADD) & alu_ic;
  assign sh     = alu_a[SHAMT_WIDTH-1:0];
  assign sum    = {1'b0, alu_b} + {1'b0, alu_a} + {{WORD_WIDTH{1'b0}}, ic_eff};

  // Operation select; c/v are only meaningful for ADD and read as 0 otherwise.
  always_comb begin
    res   = alu_b;
    c_res = 1'b0;
    v_res = 1'b0;
    case (alu_opcode)
      `OP_ADD: begin
        res   = sum[MSB:0];
        c_res = sum[WORD_WIDTH];
        v_res = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
      end
      `OP_LSL: res = alu_b << sh;
      `OP_LSR: res = alu_b >> sh;
      `OP_ASR: res = $signed(alu_b) >>> sh;
      // A shift by the full width yields 0, so sh=0 rotates cleanly.
      `OP_CSL: res = (alu_b << sh) | (alu_b >> (WORD_WIDTH - int'(sh)));
      `OP_CSR: res = (alu_b >> sh) | (alu_b << (WORD_WIDTH - int'(sh)));
      `OP_AND: res = alu_a & alu_b;
      `OP_OR:  res = alu_a | alu_b;
      `OP_XOR: res = alu_a ^ alu_b;
      default: res = alu_b;
    endcase
  end

  // Result buffer: write at tail on accept, advance head on pop; flush empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        mem[tail] <= res;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Architectural flags commit at accept under their store bits; flush leaves them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (store_carry)    carry    <= c_res;
      if (store_overflow) overflow <= v_res;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table, hand-written backpressure /
// flush / async-reset sequences, then randomized traffic against a
// queue-based reference model.

`ifndef OP_NOP
`define OP_NOP 4'h0
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif
`ifndef OP_LSL
`define OP_LSL 4'h2
`endif
`ifndef OP_LSR
`define OP_LSR 4'h3
`endif
`ifndef OP_ASR
`define OP_ASR 4'h4
`endif
`ifndef OP_CSL
`define OP_CSL 4'h5
`endif
`ifndef OP_CSR
`define OP_CSR 4'h6
`endif
`ifndef OP_AND
`define OP_AND 4'h7
`endif
`ifndef OP_OR
`define OP_OR 4'h8
`endif
`ifndef OP_XOR
`define OP_XOR 4'h9
`endif

module tb_alu_exec_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_ic, store_carry, store_overflow;
  logic [3:0]    alu_opcode;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          carry, overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .store_carry(store_carry), .store_overflow(store_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .carry(carry), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         ic, sc, so;
    logic [W-1:0] r;
    logic         c, v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: computed bit-by-bit / with wide integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ic,
                                 output logic [W-1:0] r, output logic c, output logic v);
    longint unsigned s;
    int amt;
    amt = int'(a % W);
    r = b; c = 1'b0; v = 1'b0;
    case (op)
      `OP_ADD: begin
        s = longint'(b) + longint'(a) + longint'(ic);
        r = s[W-1:0];
        c = s[W];
        v = ($signed(a) < 0) == ($signed(b) < 0) && (($signed(r) < 0) != ($signed(a) < 0));
      end
      `OP_LSL: for (int i = 0; i < amt; i++) r = r * 2;
      `OP_LSR: for (int i = 0; i < amt; i++) r = r / 2;
      `OP_ASR: for (int i = 0; i < amt; i++) r = {r[W-1], r[W-1:1]};
      `OP_CSL: for (int i = 0; i < amt; i++) r = {r[W-2:0], r[W-1]};
      `OP_CSR: for (int i = 0; i < amt; i++) r = {r[0], r[W-1:1]};
      `OP_AND: for (int i = 0; i < W; i++) r[i] = a[i] && b[i];
      `OP_OR:  for (int i = 0; i < W; i++) r[i] = a[i] || b[i];
      `OP_XOR: for (int i = 0; i < W; i++) r[i] = a[i] != b[i];
      default: r = b;
    endcase
  endfunction

  task automatic idle();
    in_valid = 0; flush = 0; alu_a = '0; alu_b = '0; alu_ic = 0;
    alu_opcode = `OP_NOP; store_carry = 0; store_overflow = 0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ic, input logic sc, input logic so);
    in_valid = 1; alu_opcode = op; alu_a = a; alu_b = b;
    alu_ic = ic; store_carry = sc; store_overflow = so;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; idle(); out_ready = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ic, input logic sc, input logic so,
                         input logic [W-1:0] r, input logic c, input logic v);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.ic = ic; t.sc = sc; t.so = so;
    t.r = r; t.c = c; t.v = v;
    vecs.push_back(t);
  endtask

  logic [W-1:0] q[$];
  logic         m_c, m_v;

  initial begin
    reset = 1; out_ready = 1; idle();
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_carry", {31'b0, carry}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 1);

    // ---------------- directed table (flags chain through the list) --------
    add_vec(`OP_ADD, 32'h1, 32'hFFFF_FFFF, 0, 1, 1, 32'h0, 1, 0);
    add_vec(`OP_ADD, 32'h0, 32'h0, 1, 0, 0, 32'h1, 1, 0);
    add_vec(`OP_ADD, 32'h1, 32'h7FFF_FFFF, 0, 1, 1, 32'h8000_0000, 0, 1);
    add_vec(`OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 32'h0000_F000, 0, 1);
    add_vec(`OP_LSR, 32'h4, 32'h8000_0001, 0, 0, 0, 32'h0800_0000, 0, 1);
    add_vec(`OP_ASR, 32'h4, 32'h8000_0001, 0, 0, 0, 32'hF800_0000, 0, 1);
    add_vec(`OP_CSL, 32'h1, 32'h8000_0001, 0, 0, 0, 32'h0000_0003, 0, 1);
    add_vec(`OP_LSL, 32'd33, 32'h8000_0001, 0, 0, 0, 32'h0000_0002, 0, 1);
    add_vec(`OP_CSR, 32'h1, 32'h8000_0001, 0, 0, 0, 32'hC000_0000, 0, 1);
    add_vec(`OP_OR,  32'h0F00_00F0, 32'h00F0_000F, 1, 0, 0, 32'h0FF0_00FF, 0, 1);
    add_vec(`OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 32'hFFFF_FFFF, 1, 1);
    add_vec(`OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1, 1, 32'hF0F0_F0F0, 0, 0);
    add_vec(`OP_NOP, 32'h1234_5678, 32'hCAFE_BABE, 1, 0, 0, 32'hCAFE_BABE, 0, 0);
    add_vec(4'hF,    32'h1234_5678, 32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ic, vecs[i].sc, vecs[i].so);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].r);
      chk($sformatf("vec%0d_carry", i), {31'b0, carry}, {31'b0, vecs[i].c});
      chk($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].v});
    end
    @(negedge clk);
    chk("drain_valid", {31'b0, out_valid}, 0);

    // ---------------- backpressure -----------------------------------------
    do_reset();
    out_ready = 0;
    drive(`OP_OR, 32'h11, 32'h0, 0, 0, 0);
    #1 chk("bp_ready0", {31'b0, in_ready}, 1);
    @(negedge clk);
    drive(`OP_OR, 32'h22, 32'h0, 0, 0, 0);
    #1 chk("bp_ready1", {31'b0, in_ready}, 1);
    @(negedge clk);
    drive(`OP_OR, 32'h33, 32'h0, 0, 0, 0);
    #1 chk("bp_ready2", {31'b0, in_ready}, 0);
    chk("bp_head0", out_result, 32'h11);
    @(negedge clk);
    out_ready = 1;
    #1 chk("bp_ready3", {31'b0, in_ready}, 0);
    chk("bp_pop1", out_result, 32'h11);
    @(negedge clk);
    #1 chk("bp_ready4", {31'b0, in_ready}, 1);
    chk("bp_pop2", out_result, 32'h22);
    @(negedge clk);
    in_valid = 0;
    chk("bp_pop3", out_result, 32'h33);
    chk("bp_valid3", {31'b0, out_valid}, 1);
    @(negedge clk);
    chk("bp_empty", {31'b0, out_valid}, 0);

    // ---------------- flush with full buffer -------------------------------
    do_reset();
    out_ready = 0;
    drive(`OP_ADD, 32'h1, 32'hFFFF_FFFF, 0, 1, 1);   // carry=1, ovf=0
    @(negedge clk);
    drive(`OP_OR, 32'h5, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(`OP_ADD, 32'h1, 32'h7FFF_FFFF, 0, 1, 1);   // would clear carry, set ovf
    flush = 1;
    #1 chk("fl_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("fl_valid", {31'b0, out_valid}, 0);
    chk("fl_carry", {31'b0, carry}, 1);
    chk("fl_ovf", {31'b0, overflow}, 0);
    #1 chk("fl_ready_after", {31'b0, in_ready}, 1);

    // ---------------- async reset mid-cycle --------------------------------
    @(negedge clk);
    out_ready = 0;
    drive(`OP_ADD, 32'h1, 32'hFFFF_FFFF, 0, 1, 0);
    @(negedge clk);
    drive(`OP_OR, 32'h7, 32'h0, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    chk("ar_pre_carry", {31'b0, carry}, 1);
    chk("ar_pre_valid", {31'b0, out_valid}, 1);
    #2 reset = 1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 0);
    chk("ar_carry", {31'b0, carry}, 0);
    chk("ar_ovf", {31'b0, overflow}, 0);
    chk("ar_result", out_result, 0);
    @(negedge clk);
    reset = 0; out_ready = 1;
    #1 chk("ar_ready", {31'b0, in_ready}, 1);
    drive(`OP_XOR, 32'hA5, 32'h0F, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    chk("ar_first", out_result, 32'hAA);
    @(negedge clk);
    chk("ar_alone", {31'b0, out_valid}, 0);

    // ---------------- randomized against model -----------------------------
    do_reset();
    q.delete(); m_c = 0; m_v = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic m_rdy, acc, pp, c, v;
      logic [W-1:0] r;
      @(negedge clk);
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("rnd_result", out_result, q[0]);
      chk("rnd_carry", {31'b0, carry}, {31'b0, m_c});
      chk("rnd_ovf", {31'b0, overflow}, {31'b0, m_v});
      drive(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) alu_a = {$urandom, 5'($urandom)} >> 32 | 32'($urandom_range(0, 40));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      m_rdy = (q.size() < 2) && !flush;
      #1 chk("rnd_ready", {31'b0, in_ready}, {31'b0, m_rdy});
      acc = in_valid && m_rdy;
      pp  = (q.size() != 0) && out_ready;
      ref_op(alu_opcode, alu_a, alu_b, alu_ic, r, c, v);
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(r);
      end
      if (acc && store_carry)    m_c = c;
      if (acc && store_overflow) m_v = v;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
